// File: rtl/ext_mem_loader_pkg.sv
// Shared types and helpers for the boot/load engine: FSM states, memory target codes
// and the beats-per-word derivation.
package riscv_ld_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ldState_t;

  localparam logic TGT_IMEM = 1'b0;
  localparam logic TGT_DMEM = 1'b1;

  function automatic int beatsPerWord(input int xlen, input int dinW);
    return xlen / dinW;
  endfunction

endpackage

// File: rtl/ext_mem_loader_packer.sv
// Collects DIN_W-bit beats into an XLEN-bit word, little-endian (first beat in the LSBs).
// wordFull flags the beat that completes the word, so the caller can act on that edge.
module word_packer
  import riscv_ld_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DIN_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             flush,
  input  logic             shiftEn,
  input  logic [DIN_W-1:0] din,
  output logic             wordFull,
  output logic [XLEN-1:0]  word
);

  localparam int BEATS = beatsPerWord(XLEN, DIN_W);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (XLEN % DIN_W != 0) begin : gWidthCheck
    $error("word_packer: DIN_W must divide XLEN");
  end

  logic [BEAT_W-1:0] beatCntReg;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      beatCntReg <= '0;
    end else if (flush) begin
      beatCntReg <= '0;
    end else if (shiftEn) begin
      beatCntReg <= (beatCntReg == LAST_BEAT) ? '0 : beatCntReg + BEAT_W'(1);
    end
  end

  assign wordFull = shiftEn && (beatCntReg == LAST_BEAT);

  // Each lane latches the beat whose index matches the running count.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : gLane
      logic [DIN_W-1:0] laneReg;

      always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
          laneReg <= '0;
        end else if (flush) begin
          laneReg <= '0;
        end else if (shiftEn && (beatCntReg == BEAT_W'(gi))) begin
          laneReg <= din;
        end
      end

      assign word[gi*DIN_W +: DIN_W] = laneReg;
    end
  endgenerate

endmodule

// File: rtl/ext_mem_loader.sv
// Boot/load engine: packs a beat stream into words, writes them to instruction or data
// memory at incrementing addresses, and holds the core in reset while doing so.
module ext_mem_loader
  import riscv_ld_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DIN_W  = 8,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_target,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [CNT_W-1:0]  ld_count,
  input  logic              s_valid,
  input  logic [DIN_W-1:0]  s_data,
  output logic              s_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              cpu_reset,
  input  logic              cpu_MemWrite,
  input  logic [ADDR_W-1:0] cpu_DataAdr,
  input  logic [XLEN-1:0]   cpu_WriteData,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(XLEN / 8);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  if (XLEN % DIN_W != 0) begin : gWidthCheck
    $error("ext_mem_loader: DIN_W must divide XLEN");
  end

  ldState_t          stateReg;
  logic              targetReg;
  logic [ADDR_W-1:0] addrReg;
  logic [CNT_W-1:0]  remainReg;
  logic              busyReg;
  logic              doneReg;
  logic              readyReg;
  logic              wrEnReg;

  logic              beatFire;
  logic              wordFull;
  logic [XLEN-1:0]   packedWord;

  assign beatFire = s_valid & readyReg;

  word_packer #(
    .XLEN  (XLEN),
    .DIN_W (DIN_W)
  ) uPacker (
    .clk      (clk),
    .clear    (reset),
    .flush    (stateReg == IDLE),
    .shiftEn  (beatFire),
    .din      (s_data),
    .wordFull (wordFull),
    .word     (packedWord)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg  <= IDLE;
      targetReg <= TGT_IMEM;
      addrReg   <= '0;
      remainReg <= '0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      readyReg  <= 1'b0;
      wrEnReg   <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      wrEnReg <= 1'b0;
      unique case (stateReg)
        IDLE: begin
          if (ld_start) begin
            targetReg <= ld_target;
            addrReg   <= ld_base & WORD_MASK;
            remainReg <= ld_count;
            busyReg   <= 1'b1;
            if (ld_count != '0) begin
              stateReg <= FILL;
              readyReg <= 1'b1;
            end else begin
              stateReg <= DONE;
              doneReg  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (wordFull) begin
            stateReg <= WRITE;
            readyReg <= 1'b0;
            wrEnReg  <= 1'b1;
          end
        end
        WRITE: begin
          addrReg   <= addrReg + ADDR_STEP;
          remainReg <= remainReg - CNT_W'(1);
          if (remainReg == CNT_W'(1)) begin
            stateReg <= DONE;
            doneReg  <= 1'b1;
          end else begin
            stateReg <= FILL;
            readyReg <= 1'b1;
          end
        end
        DONE: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign s_ready   = readyReg;
  assign ld_busy   = busyReg;
  assign ld_done   = doneReg;
  assign cpu_reset = reset | busyReg;

  assign imem_we    = wrEnReg & (targetReg == TGT_IMEM);
  assign imem_addr  = addrReg;
  assign imem_wdata = packedWord;

  // While loading, the core's store port is cut off entirely.
  assign dmem_we    = busyReg ? (wrEnReg & (targetReg == TGT_DMEM)) : cpu_MemWrite;
  assign dmem_addr  = busyReg ? addrReg    : cpu_DataAdr;
  assign dmem_wdata = busyReg ? packedWord : cpu_WriteData;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed bench for ext_mem_loader; a negedge monitor compares every memory write
// against a queue of expected writes filled as each load is issued.
module tb_ext_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_start;
  logic        ld_target;
  logic [31:0] ld_base;
  logic [15:0] ld_count;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        cpu_reset;
  logic        cpu_MemWrite;
  logic [31:0] cpu_DataAdr;
  logic [31:0] cpu_WriteData;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  always #5 clk = ~clk;

  ext_mem_loader #(.XLEN(32), .DIN_W(8), .ADDR_W(32), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .ld_start      (ld_start),
    .ld_target     (ld_target),
    .ld_base       (ld_base),
    .ld_count      (ld_count),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .ld_busy       (ld_busy),
    .ld_done       (ld_done),
    .cpu_reset     (cpu_reset),
    .cpu_MemWrite  (cpu_MemWrite),
    .cpu_DataAdr   (cpu_DataAdr),
    .cpu_WriteData (cpu_WriteData),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata)
  );

  typedef struct {
    logic        tgt;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t expQ[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mkWr(input logic tgt, input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.tgt  = tgt;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

  // Loader writes are imem_we at any time, or dmem_we while the loader owns the port.
  always @(negedge clk) begin : monitor
    wr_t         e;
    logic        obsTgt;
    logic [31:0] obsAddr;
    logic [31:0] obsData;
    if (imem_we === 1'b1 || (dmem_we === 1'b1 && ld_busy === 1'b1)) begin
      obsTgt  = (imem_we === 1'b1) ? 1'b0 : 1'b1;
      obsAddr = obsTgt ? dmem_addr  : imem_addr;
      obsData = obsTgt ? dmem_wdata : imem_wdata;
      $display("write tgt=%0d addr=0x%08h data=0x%08h", obsTgt, obsAddr, obsData);
      chk("singlePortWe", 32'(imem_we & dmem_we & ld_busy), 32'd0);
      chk("writeExpected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        chk("wrTarget", 32'(obsTgt), 32'(e.tgt));
        chk("wrAddr", obsAddr, e.addr);
        chk("wrData", obsData, e.data);
      end
    end
  end

  task automatic startLoad(input logic tgt, input logic [31:0] base, input logic [15:0] cnt);
    ld_target = tgt;
    ld_base   = base;
    ld_count  = cnt;
    ld_start  = 1'b1;
    @(negedge clk);
    ld_start  = 1'b0;
  endtask

  task automatic sendBeat(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("beatAccepted", 32'(n < 50), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // The write must appear the cycle right after the final beat of the word.
  task automatic sendWord(input logic tgt, input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap && i > 0) @(negedge clk);
      sendBeat(w[8*i +: 8]);
    end
    chk("writeLatency", 32'(tgt ? dmem_we : imem_we), 32'd1);
  endtask

  task automatic finishLoad(input string tag);
    @(negedge clk);
    chk({tag, "_doneHigh"}, 32'(ld_done), 32'd1);
    chk({tag, "_busyInDone"}, 32'(ld_busy), 32'd1);
    chk({tag, "_cpuResetInDone"}, 32'(cpu_reset), 32'd1);
    @(negedge clk);
    chk({tag, "_doneLow"}, 32'(ld_done), 32'd0);
    chk({tag, "_busyLow"}, 32'(ld_busy), 32'd0);
    chk({tag, "_cpuResetLow"}, 32'(cpu_reset), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    reset         = 1'b1;
    ld_start      = 1'b0;
    ld_target     = 1'b0;
    ld_base       = '0;
    ld_count      = '0;
    s_valid       = 1'b0;
    s_data        = '0;
    cpu_MemWrite  = 1'b0;
    cpu_DataAdr   = '0;
    cpu_WriteData = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rstBusy", 32'(ld_busy), 32'd0);
    chk("rstDone", 32'(ld_done), 32'd0);
    chk("rstReady", 32'(s_ready), 32'd0);
    chk("rstImemWe", 32'(imem_we), 32'd0);
    chk("rstCpuReset", 32'(cpu_reset), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("postRstCpuReset", 32'(cpu_reset), 32'd0);

    // Case 1: two instruction words from base 0
    expQ.push_back(mkWr(1'b0, 32'h0000_0000, 32'h00A0_0513));
    expQ.push_back(mkWr(1'b0, 32'h0000_0004, 32'h0050_0593));
    startLoad(1'b0, 32'h0, 16'd2);
    sendWord(1'b0, 32'h00A0_0513, 1'b0);
    sendWord(1'b0, 32'h0050_0593, 1'b0);
    finishLoad("c1");

    // Case 2: data word, unaligned base is truncated
    expQ.push_back(mkWr(1'b1, 32'h0000_0100, 32'hDEAD_BEEF));
    startLoad(1'b1, 32'h0000_0103, 16'd1);
    sendWord(1'b1, 32'hDEAD_BEEF, 1'b0);
    finishLoad("c2");

    // Case 3: zero-length load goes straight to DONE
    startLoad(1'b0, 32'h0000_0200, 16'd0);
    chk("c3_doneHigh", 32'(ld_done), 32'd1);
    chk("c3_busyHigh", 32'(ld_busy), 32'd1);
    @(negedge clk);
    chk("c3_doneLow", 32'(ld_done), 32'd0);
    chk("c3_busyLow", 32'(ld_busy), 32'd0);

    // Case 4: gappy stream and a start request mid-load that must be dropped
    expQ.push_back(mkWr(1'b0, 32'h0000_0000, 32'h00A0_0513));
    expQ.push_back(mkWr(1'b0, 32'h0000_0004, 32'h0050_0593));
    startLoad(1'b0, 32'h0, 16'd2);
    sendWord(1'b0, 32'h00A0_0513, 1'b1);
    ld_target = 1'b1;
    ld_base   = 32'h0000_0080;
    ld_count  = 16'd3;
    ld_start  = 1'b1;
    repeat (2) @(negedge clk);
    ld_start  = 1'b0;
    sendWord(1'b0, 32'h0050_0593, 1'b1);
    finishLoad("c4");
    repeat (2) begin
      @(negedge clk);
      chk("c4_startNotQueued", 32'(ld_busy), 32'd0);
    end

    // Case 5: reset after three beats discards the partial word
    startLoad(1'b0, 32'h0000_0040, 16'd1);
    sendBeat(8'hAA);
    sendBeat(8'hBB);
    sendBeat(8'hCC);
    reset = 1'b1;
    @(negedge clk);
    chk("c5_busy", 32'(ld_busy), 32'd0);
    chk("c5_ready", 32'(s_ready), 32'd0);
    chk("c5_imemWe", 32'(imem_we), 32'd0);
    chk("c5_cpuReset", 32'(cpu_reset), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("c5_cpuResetLow", 32'(cpu_reset), 32'd0);
    expQ.push_back(mkWr(1'b0, 32'h0000_0040, 32'h1122_3344));
    startLoad(1'b0, 32'h0000_0040, 16'd1);
    sendWord(1'b0, 32'h1122_3344, 1'b0);
    finishLoad("c5");

    // Case 6: address wrap, with core store requests active and ignored during the load
    cpu_MemWrite  = 1'b1;
    cpu_DataAdr   = 32'h0000_0055;
    cpu_WriteData = 32'h1234_5678;
    expQ.push_back(mkWr(1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D));
    expQ.push_back(mkWr(1'b1, 32'h0000_0000, 32'hFEED_FACE));
    startLoad(1'b1, 32'hFFFF_FFFC, 16'd2);
    sendWord(1'b1, 32'h0BAD_F00D, 1'b0);
    sendWord(1'b1, 32'hFEED_FACE, 1'b0);
    finishLoad("c6");
    chk("idleDmemWe", 32'(dmem_we), 32'd1);
    chk("idleDmemAddr", dmem_addr, 32'h0000_0055);
    chk("idleDmemData", dmem_wdata, 32'h1234_5678);
    chk("idleImemWe", 32'(imem_we), 32'd0);
    cpu_MemWrite = 1'b0;
    @(negedge clk);
    chk("idleDmemWeLow", 32'(dmem_we), 32'd0);

    chk("queueDrained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
